rst_seq: RTL and testbench

//  Testbench reset sequencer sitting directly downstream of the clock generator.
//  It consumes clk and a raw async reset.
//  It produces a DUT reset: asserted asynchronously, released synchronously, stretched.
//  It also services a 4-phase software reset request/acknowledge from the UVM env,
//  so tests can re-reset the DUT mid-run without touching the raw reset.

---
 rtl/rst_seq.sv | 96 +++++++++
 tb/tb_rst_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer producing a stretched DUT reset with software re-reset handshake
//   clk         in   free-running clock
//   rst_n       in   raw reset, async, active-low
//   sw_rst_req  in   software reset request, level, 4-phase
//   rst_out_n   out  DUT reset, async assert, sync release
//   rst_active  out  registered inverse of rst_out_n
//   sw_rst_ack  out  software reset done, held until request drops
//   por_done    out  sticky once the power-on hold completes
//   sw_rst_cnt  out  completed software resets, modulo 256
module rst_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int SW_RST_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    output logic       rst_out_n,
    output logic       rst_active,
    output logic       sw_rst_ack,
    output logic       por_done,
    output logic [7:0] sw_rst_cnt
);
    typedef enum logic [2:0] {ASSERT, HOLD, RUN, SW_HOLD, ACK} state_t;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   out_nxt, ack_nxt, por_nxt;
    logic [7:0]             sw_cnt_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ASSERT;
            cnt        <= '0;
            sync       <= '0;
            rst_out_n  <= 1'b0;
            rst_active <= 1'b1;
            sw_rst_ack <= 1'b0;
            por_done   <= 1'b0;
            sw_rst_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sync       <= {sync[SYNC_STAGES-2:0], 1'b1};
            rst_out_n  <= out_nxt;
            rst_active <= ~out_nxt;
            sw_rst_ack <= ack_nxt;
            por_done   <= por_nxt;
            sw_rst_cnt <= sw_cnt_nxt;
        end
    end
    // The chain is "full" on the edge that shifts a 1 into its last stage,
    // so HOLD begins at edge SYNC_STAGES and release lands on SYNC_STAGES+HOLD_CYCLES.
    // A request already pending when the POR hold expires goes straight to
    // SW_HOLD so rst_out_n never pulses high for a single cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ASSERT: begin
                cnt_nxt = '0;
                if (sync[SYNC_STAGES-2]) state_nxt = HOLD;
            end
            HOLD: if (cnt == HOLD_LAST) begin
                state_nxt = sw_rst_req ? SW_HOLD : RUN;
                cnt_nxt   = '0;
            end
            RUN: begin
                cnt_nxt = '0;
                if (sw_rst_req) state_nxt = SW_HOLD;
            end
            SW_HOLD: if (cnt == SW_LAST) begin
                state_nxt = ACK;
                cnt_nxt   = '0;
            end
            ACK: begin
                cnt_nxt = '0;
                if (!sw_rst_req) state_nxt = RUN;
            end
            default: begin
                state_nxt = ASSERT;
                cnt_nxt   = '0;
            end
        endcase
    end
    // Outputs are registered from the next state, so they change on the same
    // edge as the state and rst_out_n comes straight from a flop.
    always_comb begin
        out_nxt    = state_nxt == RUN || state_nxt == ACK;
        ack_nxt    = state_nxt == ACK;
        por_nxt    = por_done | (state == HOLD && state_nxt != HOLD);
        sw_cnt_nxt = sw_rst_cnt + 8'(state == SW_HOLD && state_nxt == ACK);
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of POR stretching, software reset handshake and aborts
module tb_rst_seq;
    logic       clk = 1'b0, rst_n = 1'b1, sw_rst_req = 1'b0;
    logic       rst_out_n, rst_active, sw_rst_ack, por_done;
    logic [7:0] sw_rst_cnt;
    logic [7:0] exp_cnt;
    int         checks = 0, errors = 0, e = 0;

    typedef struct {
        int         e;
        logic       req;
        logic       o, a, k, p;
        logic [7:0] c;
    } vec_t;
    vec_t v[11];

    rst_seq dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .rst_out_n(rst_out_n), .rst_active(rst_active), .sw_rst_ack(sw_rst_ack),
        .por_done(por_done), .sw_rst_cnt(sw_rst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic o, a, k, p, input logic [7:0] c);
        checks++;
        if ({rst_out_n, rst_active, sw_rst_ack, por_done, sw_rst_cnt} !== {o, a, k, p, c}) begin
            errors++;
            $display("FAIL %s: got out=%b act=%b ack=%b por=%b cnt=%0d, want out=%b act=%b ack=%b por=%b cnt=%0d",
                     nm, rst_out_n, rst_active, sw_rst_ack, por_done, sw_rst_cnt, o, a, k, p, c);
        end
    endtask

    task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        v[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[2]  = '{17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[3]  = '{18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        v[4]  = '{29, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        v[5]  = '{30, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        v[6]  = '{37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        v[7]  = '{38, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        v[8]  = '{39, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        v[9]  = '{40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        v[10] = '{41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};

        // POR then one software reset, edges counted from release
        #2 rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            while (e < v[i].e) begin
                tick(1);
                e++;
            end
            chk($sformatf("vec%0d_edge%0d", i, v[i].e), v[i].o, v[i].a, v[i].k, v[i].p, v[i].c);
            sw_rst_req = v[i].req;
        end

        // raw reset during SW_HOLD aborts and replays POR
        sw_rst_req = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1 chk("abort_sw_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        sw_rst_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(17);
        chk("replay_edge17", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk("replay_edge18", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

        // raw reset during ACK drops ack asynchronously
        sw_rst_req = 1'b1;
        tick(9);
        chk("ack_before_abort", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        #2 rst_n = 1'b0;
        #1 chk("abort_ack", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        sw_rst_req = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // raw reset pulse mid-HOLD restarts the full sequence
        tick(10);
        rst_n = 1'b0;
        #1 chk("hold_glitch_async", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk("hold_glitch_low", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(17);
        chk("hold_restart_edge17", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk("hold_restart_edge18", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

        // request held through POR: software hold runs edges 18..25, ack at 26
        rst_n = 1'b0;
        sw_rst_req = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(17);
        chk("req_por_edge17", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk1("req_por_out_edge18", 8'(rst_out_n), 8'd0);
        tick(7);
        chk1("req_por_out_edge25", 8'(rst_out_n), 8'd0);
        chk1("req_por_ack_edge25", 8'(sw_rst_ack), 8'd0);
        tick(1);
        chk("req_por_edge26", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        sw_rst_req = 1'b0;
        tick(1);
        chk("req_por_ack_drop", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);

        // 255 more software resets wrap the counter back to 0
        exp_cnt = 8'd1;
        for (int i = 0; i < 255; i++) begin
            sw_rst_req = 1'b1;
            tick(9);
            exp_cnt++;
            chk($sformatf("loop%0d_ack", i), 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt);
            if (i == 0 || i == 254) begin
                tick(3);
                chk($sformatf("loop%0d_ack_held", i), 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt);
            end
            sw_rst_req = 1'b0;
            tick(1);
            chk($sformatf("loop%0d_run", i), 1'b1, 1'b0, 1'b0, 1'b1, exp_cnt);
        end
        chk1("cnt_wrapped", sw_rst_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
